// File: rtl/err_tlm_pkg.sv
// Shared constants, field positions and state encoding for the error-telemetry word serializer.
package err_tlm_pkg;

  localparam int WORD_W = 26;
  localparam int TT_W   = 12;
  localparam int SEQ_W  = 5;
  localparam int CNT_W  = 5;

  localparam int EMRG_HI  = 25;
  localparam int EMRG_LO  = 22;
  localparam int ETCC_BIT = 21;
  localparam int ETCR_BIT = 20;
  localparam int TAGS_BIT = 19;
  localparam int OVR_BIT  = 18;
  localparam int SEQ_HI   = 17;
  localparam int SEQ_LO   = 13;
  localparam int TT_HI    = 12;
  localparam int TT_LO    = 1;
  localparam int PAR_BIT  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } tlm_state_e;

  // Parity bit that makes the total count of ones in the word odd.
  function automatic logic odd_par(input logic [WORD_W-1:0] w);
    return ~(^w[WORD_W-1:1]);
  endfunction

  // Overrun and sequence reflect emission order, so they are written when the word is loaded.
  function automatic logic [WORD_W-1:0] stamp_word(input logic [WORD_W-1:0] w,
                                                   input logic             ovr,
                                                   input logic [SEQ_W-1:0] seq);
    logic [WORD_W-1:0] r;
    r                = w;
    r[OVR_BIT]       = ovr;
    r[SEQ_HI:SEQ_LO] = seq;
    r[PAR_BIT]       = odd_par(r);
    return r;
  endfunction

endpackage

// File: rtl/err_tlm_word_fmt.sv
// Combinational assembly of the 26-bit telemetry word with odd parity.
module err_tlm_word_fmt
  import err_tlm_pkg::*;
(
  input  logic [3:0]        emrg,
  input  logic              etcc,
  input  logic              etcr,
  input  logic              tags,
  input  logic              ovr,
  input  logic [SEQ_W-1:0]  seq,
  input  logic [TT_W-1:0]   tt,
  output logic [WORD_W-1:0] word
);

  function automatic logic [WORD_W-1:0] assemble(input logic [3:0]       e,
                                                 input logic             cc,
                                                 input logic             cr,
                                                 input logic             tg,
                                                 input logic             ov,
                                                 input logic [SEQ_W-1:0] sq,
                                                 input logic [TT_W-1:0]  t);
    logic [WORD_W-1:0] w;
    w                  = '0;
    w[EMRG_HI:EMRG_LO] = e;
    w[ETCC_BIT]        = cc;
    w[ETCR_BIT]        = cr;
    w[TAGS_BIT]        = tg;
    w[OVR_BIT]         = ov;
    w[SEQ_HI:SEQ_LO]   = sq;
    w[TT_HI:TT_LO]     = t;
    w[PAR_BIT]         = odd_par(w);
    return w;
  endfunction

  assign word = assemble(emrg, etcc, etcr, tags, ovr, seq, tt);

endmodule

// File: rtl/err_tlm_word_ser.sv
// Captures error-telemetry status into a time-tagged word and shifts it out MSB-first on V1 strobes.
module err_tlm_word_ser
  import err_tlm_pkg::*;
(
  input  logic SIM_CLK,
  input  logic SIM_RST,
  input  logic V1,
  input  logic ETTS,
  input  logic ETCC,
  input  logic ETCR,
  input  logic TAGS,
  input  logic EMRG1,
  input  logic EMRG2,
  input  logic EMRG3,
  input  logic EMRG4,
  input  logic TLMRQ,
  output logic TLMD,
  output logic TLMB,
  output logic TLMW,
  output logic BUSY,
  output logic OVRN
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  tlm_state_e        state;
  logic              etts_q;
  logic              pv;
  logic              ovrn;
  logic              tlmd;
  logic              tlmb;
  logic              tlmw;
  logic [TT_W-1:0]   tt;
  logic [SEQ_W-1:0]  seq;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] pend;
  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] fmt_word;
  logic              capture;
  logic              cap_accept;
  logic              shift_en;

  assign capture    = ETTS & ~etts_q;
  // A capture in the LOAD cycle refills PEND as LOAD drains it, so it is never an overrun.
  assign cap_accept = capture & (~pv | (state == LOAD));
  assign shift_en   = (state == SHIFT) & V1 & TLMRQ;

  err_tlm_word_fmt u_fmt (
    .emrg (4'({EMRG4, EMRG3, EMRG2, EMRG1})),
    .etcc (ETCC),
    .etcr (ETCR),
    .tags (TAGS),
    .ovr  (ovrn),
    .seq  (seq),
    .tt   (tt),
    .word (fmt_word)
  );

  // Word datapath: pending buffer and shift register carry no reset.
  always_ff @(posedge SIM_CLK) begin
    if (state == LOAD) begin
      sreg <= stamp_word(pend, ovrn, seq);
    end else if (shift_en) begin
      sreg <= {sreg[WORD_W-2:0], 1'b0};
    end
    if (cap_accept) begin
      pend <= fmt_word;
    end
  end

  // Control: edge detect, pending flag, FSM, counters and registered outputs.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state  <= IDLE;
      etts_q <= 1'b1;
      pv     <= 1'b0;
      ovrn   <= 1'b0;
      tt     <= '0;
      seq    <= '0;
      cnt    <= '0;
      tlmd   <= 1'b0;
      tlmb   <= 1'b0;
      tlmw   <= 1'b0;
    end else begin
      etts_q <= ETTS;
      tlmb   <= 1'b0;
      tlmw   <= 1'b0;
      if (V1) begin
        tt <= tt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (pv) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          pv    <= 1'b0;
          ovrn  <= 1'b0;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (shift_en) begin
            tlmd <= sreg[WORD_W-1];
            tlmb <= 1'b1;
            cnt  <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          tlmw  <= 1'b1;
          seq   <= seq + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (cap_accept) begin
        pv <= 1'b1;
      end else if (capture) begin
        ovrn <= 1'b1;
      end
    end
  end

  assign TLMD = tlmd;
  assign TLMB = tlmb;
  assign TLMW = tlmw;
  assign BUSY = (state != IDLE);
  assign OVRN = ovrn;

endmodule
